// File: rtl/rs232_pkg.sv
// rs232_pkg: shared receiver/transmitter state encoding and default link timing.
package rs232_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAPWAIT, BREAKWAIT} rx_state_t;
    localparam int DEF_CLKS_PER_BIT = 48;
    localparam int DEF_BYTES_PER_WORD = 4;
endpackage

// File: rtl/rs232_sync_edge.sv
// rs232_sync_edge: 2-flop synchroniser with falling-edge detect; idles high.
module rs232_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic s,
    output logic fall
);
    logic [2:0] r;
    always_ff @(posedge clk) r <= rst ? 3'b111 : {r[1:0], a};
    assign s = r[1];
    assign fall = r[2] & ~r[1];
endmodule

// File: rtl/rs232_rx_word.sv
// rs232_rx_word: receives 8N1 characters LSB first and packs them into words, byte 0 in the low lane.
module rs232_rx_word
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int GAP_TIMEOUT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_in,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_valid,
    output logic                        frame_err,
    output logic                        gap_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(BYTES_PER_WORD + 1);
    localparam int GW = $clog2(GAP_TIMEOUT_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BYTES_PER_WORD - 1);
    localparam logic [GW-1:0] G_MAX = GW'(GAP_TIMEOUT_BITS);
    rx_state_t st;
    logic rxs, fall;
    logic [TW-1:0] tmr;
    logic [2:0] bit_cnt;
    logic [BW-1:0] byte_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0] sh;
    logic [8*BYTES_PER_WORD-1:0] asm_reg, asm_nx;
    rs232_sync_edge u_sync (.clk(clk), .rst(rst), .a(rx_in), .s(rxs), .fall(fall));
    // assembly register with the byte just framed dropped into its lane
    always_comb begin
        asm_nx = asm_reg;
        asm_nx[8*byte_cnt +: 8] = sh;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            tmr <= '0;
            bit_cnt <= '0;
            byte_cnt <= '0;
            gap_cnt <= '0;
            sh <= '0;
            asm_reg <= '0;
            word_out <= '0;
            word_valid <= 1'b0;
            frame_err <= 1'b0;
            gap_err <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err <= 1'b0;
            gap_err <= 1'b0;
            tmr <= (tmr == T_LAST) ? '0 : tmr + 1'b1;
            case (st)
                IDLE: begin
                    tmr <= '0;
                    if (!rxs) st <= START;
                end
                START: if (tmr == T_HALF) begin
                    tmr <= '0;
                    bit_cnt <= '0;
                    frame_err <= rxs;
                    st <= rxs ? IDLE : DATA;
                end
                DATA: if (tmr == T_LAST) begin
                    sh <= {rxs, sh[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) st <= STOP;
                end
                STOP: if (tmr == T_LAST) begin
                    if (!rxs) begin
                        frame_err <= 1'b1;
                        byte_cnt <= '0;
                        st <= BREAKWAIT;
                    end else if (byte_cnt == B_LAST) begin
                        word_out <= asm_nx;
                        word_valid <= 1'b1;
                        byte_cnt <= '0;
                        st <= IDLE;
                    end else begin
                        asm_reg <= asm_nx;
                        byte_cnt <= byte_cnt + 1'b1;
                        tmr <= '0;
                        gap_cnt <= '0;
                        st <= GAPWAIT;
                    end
                end
                // a start edge beats a coincident timeout
                GAPWAIT: if (fall) begin
                    tmr <= '0;
                    st <= START;
                end else if (gap_cnt == G_MAX) begin
                    gap_err <= 1'b1;
                    byte_cnt <= '0;
                    st <= IDLE;
                end else if (tmr == T_LAST) begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                BREAKWAIT: if (rxs) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule
